// File: rtl/rom_dl_arbiter.sv
// Buffers HPS download bytes and slots them into idle cycles of the core's ROM write port,
// sequencing core reset around the download. Optional checksum: define ROM_DL_CHECKSUM_EN.
module rom_dl_arbiter #(
    parameter int ADDR_W        = 17,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_WAIT      = 7,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              Reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_req,
    output logic              cpu_stall,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              core_reset_n,
    output logic              fifo_full,
    output logic              dl_err,
    output logic [15:0]       dl_sum
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C  = WAIT_W'(MAX_WAIT);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {SETTLE, RUN, LOAD, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W+7:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               push_req, fifo_empty, issue, forced, push_ok, drop, load_entry;

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    always_comb begin
        push_req   = dl_wr & dl_active;
        fifo_empty = (count == '0);
        issue      = !fifo_empty && (!cpu_req || wait_cnt == WAIT_MAX_C);
        forced     = issue & cpu_req;
        push_ok    = push_req && (count != DEPTH_C || issue);
        drop       = push_req && !push_ok;
        count_nxt  = count;
        if (push_ok && !issue) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push_ok && issue) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Emptiness is judged on the post-edge count so settle starts on the last pop.
    always_comb begin
        state_nxt = state;
        if (dl_active) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                SETTLE:      state_nxt = (settle_cnt == SETTLE_LAST) ? RUN : SETTLE;
                RUN:         state_nxt = RUN;
                LOAD, DRAIN: state_nxt = (count_nxt == '0) ? SETTLE : DRAIN;
                default:     state_nxt = SETTLE;
            endcase
        end
        load_entry = (state != LOAD) && (state_nxt == LOAD);
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {dl_addr, dl_data};
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= SETTLE;
            settle_cnt   <= '0;
            core_reset_n <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_full    <= 1'b0;
            wait_cnt     <= '0;
            rom_we       <= 1'b0;
            cpu_stall    <= 1'b0;
            rom_addr     <= '0;
            rom_data     <= '0;
            dl_err       <= 1'b0;
        end else begin
            state        <= state_nxt;
            core_reset_n <= (state_nxt == RUN);
            if (state == SETTLE && state_nxt == SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end else begin
                settle_cnt <= '0;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr               <= rd_ptr + PTR_W'(1);
                {rom_addr, rom_data} <= fifo_mem[rd_ptr];
            end
            count     <= count_nxt;
            fifo_full <= (count_nxt == DEPTH_C);
            rom_we    <= issue;
            cpu_stall <= forced;

            if (fifo_empty || issue) begin
                wait_cnt <= '0;
            end else if (cpu_req && wait_cnt != WAIT_MAX_C) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (drop) begin
                dl_err <= 1'b1;
            end else if (load_entry) begin
                dl_err <= 1'b0;
            end
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            dl_sum <= '0;
        end else if (load_entry) begin
            dl_sum <= '0;
        end else if (rom_we) begin
            dl_sum <= dl_sum + {8'h00, rom_data};
        end
    end
`else
    assign dl_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Directed bench for rom_dl_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed cycle-exact expectations for each scenario.
module tb_rom_dl_arbiter;
    localparam int ADDR_W        = 17;
    localparam int FIFO_DEPTH    = 4;
    localparam int MAX_WAIT      = 7;
    localparam int SETTLE_CYCLES = 16;
`ifdef ROM_DL_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              Reset_n;
    logic              dl_active, dl_wr, cpu_req;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              cpu_stall, rom_we, core_reset_n, fifo_full, dl_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [15:0]       dl_sum;

    int n_cmp = 0;
    int n_bad = 0;

    rom_dl_arbiter #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_WAIT(MAX_WAIT), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk_sys(clk_sys), .Reset_n(Reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .cpu_req(cpu_req), .cpu_stall(cpu_stall),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_reset_n(core_reset_n), .fifo_full(fifo_full), .dl_err(dl_err), .dl_sum(dl_sum)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    typedef enum int {PH_SETTLE, PH_RUN, PH_LOAD, PH_DRAIN} phase_t;
    phase_t            m_phase;
    int                m_left, m_blocked, m_n;
    bit                m_go;
    logic [15:0]       m_sum;
    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] m_head;
    logic              exp_we, exp_stall, exp_rstn, exp_full, exp_err;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;

    always @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            exp_q.delete();
            m_phase = PH_SETTLE; m_left = SETTLE_CYCLES; m_blocked = 0; m_sum = 16'h0;
            exp_we = 0; exp_stall = 0; exp_rstn = 0; exp_full = 0; exp_err = 0;
            exp_addr = '0; exp_data = '0;
        end else begin
            m_n  = exp_q.size();
            m_go = (m_n > 0) && (!cpu_req || m_blocked == MAX_WAIT);
            if (dl_active && m_phase != PH_LOAD) begin
                m_sum = 16'h0;
                exp_err = 0;
            end else if (exp_we) begin
                m_sum = m_sum + 16'(exp_data);
            end
            exp_we    = m_go;
            exp_stall = m_go && cpu_req;
            if (m_go) begin
                m_head = exp_q.pop_front();
                {exp_addr, exp_data} = m_head;
            end
            if (dl_active && dl_wr) begin
                if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({dl_addr, dl_data});
                else exp_err = 1;
            end
            if (m_n == 0 || m_go) m_blocked = 0;
            else if (cpu_req && m_blocked < MAX_WAIT) m_blocked = m_blocked + 1;
            if (dl_active) begin
                m_phase = PH_LOAD;
            end else if (m_phase == PH_SETTLE) begin
                if (m_left == 1) m_phase = PH_RUN;
                else m_left = m_left - 1;
            end else if (m_phase == PH_LOAD || m_phase == PH_DRAIN) begin
                if (exp_q.size() == 0) begin
                    m_phase = PH_SETTLE;
                    m_left  = SETTLE_CYCLES;
                end else begin
                    m_phase = PH_DRAIN;
                end
            end
            exp_rstn = (m_phase == PH_RUN);
            exp_full = (exp_q.size() == FIFO_DEPTH);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit act, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d, input bit req);
        dl_active = act; dl_wr = wr; dl_addr = a; dl_data = d; cpu_req = req;
    endtask

    task automatic compare_model();
        chk("m_rom_we", rom_we, exp_we);
        chk("m_cpu_stall", cpu_stall, exp_stall);
        chk("m_rom_addr", rom_addr, exp_addr);
        chk("m_rom_data", rom_data, exp_data);
        chk("m_core_reset_n", core_reset_n, exp_rstn);
        chk("m_fifo_full", fifo_full, exp_full);
        chk("m_dl_err", dl_err, exp_err);
        chk("m_dl_sum", dl_sum, CSUM_ON ? m_sum : 16'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset_n = 1'b0;
        drive(0, 0, '0, 8'h00, 0);
        fork
            forever begin
                @(negedge clk_sys);
                if (Reset_n) compare_model();
            end
        join_none

        repeat (3) @(negedge clk_sys);
        chk("rst_rom_we", rom_we, 0);
        chk("rst_core_reset_n", core_reset_n, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_dl_err", dl_err, 0);
        chk("rst_dl_sum", dl_sum, 0);
        chk("rst_rom_addr", rom_addr, 0);
        Reset_n = 1'b1;

        // Power-up settle: core held for 16 edges, no writes.
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk_sys);
            chk("settle_we", rom_we, 0);
            chk("settle_crn", core_reset_n, j >= 16);
        end

        // 8-byte burst with an idle core: one write per clock, two clocks of latency.
        drive(1, 1, 17'h00, 8'hA0, 0);
        for (int j = 1; j <= 26; j++) begin
            @(negedge clk_sys);
            chk("burst_we", rom_we, (j >= 2 && j <= 9));
            if (j >= 2 && j <= 9) begin
                chk("burst_addr", rom_addr, j - 2);
                chk("burst_data", rom_data, 8'hA0 + 8'(j - 2));
            end
            chk("burst_crn", core_reset_n, j >= 25);
            if (j < 8) drive(1, 1, 17'(j), 8'hA0 + 8'(j), 0);
            else if (j == 8) drive(0, 0, '0, 8'h00, 0);
        end
        chk("burst_err", dl_err, 0);

        // Single byte against a busy core: forced write with stall on the 9th edge.
        drive(1, 1, 17'h100, 8'h5A, 1);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk_sys);
            chk("force_we", rom_we, j == 9);
            chk("force_stall", cpu_stall, j == 9);
            if (j == 9) begin
                chk("force_addr", rom_addr, 17'h100);
                chk("force_data", rom_data, 8'h5A);
            end
            if (j == 1) drive(1, 0, '0, 8'h00, 1);
            else if (j == 9) drive(0, 0, '0, 8'h00, 0);
        end
        chk("force_crn", core_reset_n, 0);

        // Overflow, drain under a busy core, re-entry into LOAD mid-drain.
        drive(1, 1, 17'h10, 8'hC0, 1);
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk_sys);
            chk("ovf_we", rom_we, (j == 9 || j == 17 || j == 25 || j == 33));
            chk("ovf_stall", cpu_stall, (j == 9 || j == 17 || j == 25 || j == 33));
            if (j == 9 || j == 17 || j == 25 || j == 33) begin
                chk("ovf_addr", rom_addr, 17'h10 + 17'((j - 9) / 8));
                chk("ovf_data", rom_data, 8'hC0 + 8'((j - 9) / 8));
            end
            chk("ovf_full", fifo_full, (j >= 4 && j <= 8));
            chk("ovf_err", dl_err, (j >= 5 && j <= 20));
            chk("ovf_crn", core_reset_n, j >= 49);
            if (j <= 5) drive(1, 1, 17'h10 + 17'(j), 8'hC0 + 8'(j), 1);
            else if (j == 6) drive(1, 0, '0, 8'h00, 1);
            else if (j == 9) drive(0, 0, '0, 8'h00, 1);
            else if (j == 20) drive(1, 0, '0, 8'h00, 1);
            else if (j == 22) drive(0, 0, '0, 8'h00, 1);
            else if (j == 50) drive(0, 0, '0, 8'h00, 0);
        end

        // Checksum: 0xFF + 0xFF + 0x02 wraps to 0x0200 when the feature is built.
        drive(1, 1, 17'h20, 8'hFF, 0);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk_sys);
            if (j == 1) drive(1, 1, 17'h21, 8'hFF, 0);
            else if (j == 2) drive(1, 1, 17'h22, 8'h02, 0);
            else if (j == 3) drive(0, 0, '0, 8'h00, 0);
        end
        chk("csum_value", dl_sum, CSUM_ON ? 16'h0200 : 16'h0000);

        // Reset mid-download: queued bytes are lost, sequencing restarts.
        drive(1, 1, 17'h30, 8'h11, 1);
        @(negedge clk_sys);
        drive(1, 1, 17'h31, 8'h22, 1);
        @(negedge clk_sys);
        drive(1, 0, '0, 8'h00, 1);
        @(negedge clk_sys);
        #2 Reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mid_rst_we", rom_we, 0);
        chk("mid_rst_crn", core_reset_n, 0);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_addr", rom_addr, 0);
        drive(0, 0, '0, 8'h00, 0);
        @(negedge clk_sys);
        Reset_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk_sys);
            chk("post_rst_we", rom_we, 0);
            chk("post_rst_crn", core_reset_n, j >= 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
